// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU output packer.
// Word layout is {data, strb, last}, little-endian byte lanes.
package ppu_pkg;

  localparam int PACK_BYTES_DFLT = 4;
  localparam logic [7:0] ZERO_POINT = 8'd128;

  typedef struct packed {
    logic [8*PACK_BYTES_DFLT-1:0] data;
    logic [PACK_BYTES_DFLT-1:0]   strb;
    logic                         last;
  } ppu_word_t;

  function automatic logic [7:0] relu_q(
    input logic [7:0] b
  );
    return (b < ZERO_POINT) ? ZERO_POINT : b;
  endfunction

endpackage

// File: rtl/ppu_out_packer_if.sv
// Byte-in / word-out stream bundle of the PPU output packer.
// slave = packer side, master = PPU/GLB side.
interface ppu_out_packer_if #(
  parameter int PB = 4
) ();

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [8*PB-1:0] out_data;
  logic [PB-1:0] out_strb;
  logic          out_last;
  logic [15:0]   words_out;

  modport slave (
    input  in_valid, in_data, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_data,
    output out_strb, out_last,
    output words_out
  );

  modport master (
    output in_valid, in_data, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data,
    input  out_strb, out_last,
    input  words_out
  );

endinterface

// File: rtl/ppu_word_fifo.sv
// Circular-buffer FIFO of packed output words.
// Pointers carry one extra wrap bit to tell full from empty.
module ppu_word_fifo
  import ppu_pkg::*;
#(
  parameter int W     = $bits(ppu_word_t),
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance on accepted push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ppu_out_packer.sv
// Packs quantised bytes little-endian into words for the GLB.
// Optional build macro PPU_RELU_EN clamps bytes below zero point.
module ppu_out_packer
  import ppu_pkg::*;
#(
  parameter int PACK_BYTES = PACK_BYTES_DFLT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  ppu_out_packer_if.slave bus
);

  localparam int DW = 8 * PACK_BYTES;
  localparam int W  = DW + PACK_BYTES + 1;
  localparam int IW = (PACK_BYTES > 1) ? $clog2(PACK_BYTES) : 1;

  logic [DW-1:0]         asm_data_q, asm_data_d;
  logic [PACK_BYTES-1:0] asm_strb_q, asm_strb_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [15:0]           words_q, words_d;

  logic [7:0]            byte_v;
  logic                  acc, done, pop;
  logic [DW-1:0]         data_ins;
  logic [PACK_BYTES-1:0] strb_ins;
  logic                  full, empty;
  logic [W-1:0]          head;

`ifdef PPU_RELU_EN
  assign byte_v = relu_q(bus.in_data);
`else
  assign byte_v = bus.in_data;
`endif

  assign bus.in_ready  = !rst && !full;
  assign bus.out_valid = !rst && !empty;

  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;

  assign data_ins = asm_data_q |
    (DW'(byte_v) << (8 * idx_q));
  assign strb_ins = asm_strb_q |
    (PACK_BYTES'(1) << idx_q);

  assign done = acc &&
    ((idx_q == IW'(PACK_BYTES - 1)) || bus.in_last);

  // Assembly register: insert lane, clear on word completion.
  always_comb begin
    asm_data_d = asm_data_q;
    asm_strb_d = asm_strb_q;
    idx_d      = idx_q;
    words_d    = words_q + {15'd0, pop};
    if (done) begin
      asm_data_d = '0;
      asm_strb_d = '0;
      idx_d      = '0;
    end else if (acc) begin
      asm_data_d = data_ins;
      asm_strb_d = strb_ins;
      idx_d      = idx_q + 1'b1;
    end
  end

  // State registers of the packer.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_data_q <= '0;
      asm_strb_q <= '0;
      idx_q      <= '0;
      words_q    <= '0;
    end else begin
      asm_data_q <= asm_data_d;
      asm_strb_q <= asm_strb_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
    end
  end

  ppu_word_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (done),
    .wdata_i ({data_ins, strb_ins, bus.in_last}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Empty slots may hold stale words; show zeros instead.
  assign bus.out_data  = bus.out_valid ? head[W-1 -: DW] : '0;
  assign bus.out_strb  = bus.out_valid ?
    head[PACK_BYTES:1] : '0;
  assign bus.out_last  = bus.out_valid && head[0];
  assign bus.words_out = words_q;

endmodule

// File: tb/tb_ppu_out_packer.sv
// Directed self-checking bench for ppu_out_packer.
// Works with or without PPU_RELU_EN defined.
module tb_ppu_out_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass = 0;
  int   tot  = 0;
  bit   mon_en = 1'b1;
  logic [36:0] got_q [$];

  always #5 clk = ~clk;

  ppu_out_packer_if #(.PB(4)) bus ();

  ppu_out_packer #(
    .PACK_BYTES (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs change 1 time unit after posedge, so the negedge
  // view equals what the next posedge will see.
  always @(negedge clk) begin
    if (mon_en && !rst && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_data, bus.out_strb,
                       bus.out_last});
  end

  function automatic logic [7:0] eb(input logic [7:0] b);
`ifdef PPU_RELU_EN
    return (b < 8'h80) ? 8'h80 : b;
`else
    return b;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic l);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int i = 0; i < 64; i++) begin
      if (bus.in_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      tot++;
      $display("FAIL send_timeout byte %h not accepted", d);
    end
  endtask

  task automatic wait_words(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      tot++;
      $display("FAIL wait_words got %0d want %0d",
               got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    step();
    step();
    tot++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
    else pass++;
    tot++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
    else pass++;
    tot++;
    if (bus.out_data !== 32'h0 || bus.out_strb !== 4'h0 ||
        bus.out_last !== 1'b0)
      $display("FAIL rst_head got %h/%h/%b want 0/0/0",
               bus.out_data, bus.out_strb, bus.out_last);
    else pass++;
    tot++;
    if (bus.words_out !== 16'd0)
      $display("FAIL rst_words got %0d want 0", bus.words_out);
    else pass++;
    rst = 1'b0;
    #1;
    tot++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL rst_release_ready got %b want 1",
               bus.in_ready);
    else pass++;
  endtask

  task automatic test_full_word();
    logic [31:0] exp_d;
    exp_d = {eb(8'h40), eb(8'h30), eb(8'h20), eb(8'h10)};
    bus.out_ready = 1'b1;
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b0);
    tot++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL full_early_valid got %b want 0",
               bus.out_valid);
    else pass++;
    send_byte(8'h40, 1'b0);
    idle();
    tot++;
    if (bus.out_valid !== 1'b1)
      $display("FAIL full_latency got %b want 1", bus.out_valid);
    else pass++;
    tot++;
    if (bus.out_data !== exp_d || bus.out_strb !== 4'hF ||
        bus.out_last !== 1'b0)
      $display("FAIL full_word got %h/%h/%b want %h/f/0",
               bus.out_data, bus.out_strb, bus.out_last, exp_d);
    else pass++;
    step();
    tot++;
    if (bus.words_out !== 16'd1 || bus.out_valid !== 1'b0)
      $display("FAIL full_words got %0d/%b want 1/0",
               bus.words_out, bus.out_valid);
    else pass++;
  endtask

  task automatic test_partial();
    got_q.delete();
    bus.out_ready = 1'b1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    send_byte(8'h55, 1'b1);
    idle();
    wait_words(2);
    step();
    step();
    if (got_q.size() >= 2) begin
      tot++;
      if (got_q[0] !== {32'h0000BBAA, 4'b0011, 1'b1})
        $display("FAIL partial_2b got %h want %h", got_q[0],
                 {32'h0000BBAA, 4'b0011, 1'b1});
      else pass++;
      tot++;
      if (got_q[1] !== {24'h0, eb(8'h55), 4'b0001, 1'b1})
        $display("FAIL partial_1b got %h want %h", got_q[1],
                 {24'h0, eb(8'h55), 4'b0001, 1'b1});
      else pass++;
    end
    tot++;
    if (bus.words_out !== 16'd3)
      $display("FAIL partial_words got %0d want 3",
               bus.words_out);
    else pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hC4C3C2C1;
    exp_w[1] = 32'hC8C7C6C5;
    exp_w[2] = 32'hCCCBCAC9;
    got_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++)
      send_byte(8'hC0 + 8'(i), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC9;
    for (int c = 0; c < 3; c++) begin
      tot++;
      if (bus.in_ready !== 1'b0)
        $display("FAIL bp_in_ready c%0d got %b want 0",
                 c, bus.in_ready);
      else pass++;
      tot++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[0])
        $display("FAIL bp_head c%0d got %b/%h want 1/%h",
                 c, bus.out_valid, bus.out_data, exp_w[0]);
      else pass++;
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 9; i <= 12; i++)
      send_byte(8'hC0 + 8'(i), 1'b0);
    idle();
    wait_words(3);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        tot++;
        if (got_q[i] !== {exp_w[i], 4'hF, 1'b0})
          $display("FAIL bp_word%0d got %h want %h", i,
                   got_q[i], {exp_w[i], 4'hF, 1'b0});
        else pass++;
      end
    end
    tot++;
    if (bus.words_out !== 16'd6)
      $display("FAIL bp_words got %0d want 6", bus.words_out);
    else pass++;
  endtask

  task automatic test_relu();
    logic [36:0] exp_e;
`ifdef PPU_RELU_EN
    exp_e = {32'h00FF8080, 4'b0111, 1'b1};
`else
    exp_e = {32'h00FF807F, 4'b0111, 1'b1};
`endif
    got_q.delete();
    bus.out_ready = 1'b1;
    send_byte(8'h7F, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'hFF, 1'b1);
    idle();
    wait_words(1);
    if (got_q.size() >= 1) begin
      tot++;
      if (got_q[0] !== exp_e)
        $display("FAIL relu_word got %h want %h",
                 got_q[0], exp_e);
      else pass++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_d;
    exp_d = {eb(8'h04), eb(8'h03), eb(8'h02), eb(8'h01)};
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send_byte(8'hD0 + 8'(i), 1'b0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    idle();
    tot++;
    if (bus.out_valid !== 1'b1)
      $display("FAIL mid_pre_valid got %b want 1",
               bus.out_valid);
    else pass++;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    tot++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL mid_rst_cycle got %b/%b want 0/0",
               bus.out_valid, bus.in_ready);
    else pass++;
    step();
    rst = 1'b0;
    #1;
    tot++;
    if (bus.out_valid !== 1'b0 || bus.words_out !== 16'd0 ||
        bus.out_data !== 32'h0)
      $display("FAIL mid_after got %b/%0d/%h want 0/0/0",
               bus.out_valid, bus.words_out, bus.out_data);
    else pass++;
    got_q.delete();
    for (int i = 1; i <= 4; i++)
      send_byte(8'(i), 1'b0);
    idle();
    wait_words(1);
    step();
    if (got_q.size() >= 1) begin
      tot++;
      if (got_q[0] !== {exp_d, 4'hF, 1'b0})
        $display("FAIL mid_word got %h want %h", got_q[0],
                 {exp_d, 4'hF, 1'b0});
      else pass++;
    end
    tot++;
    if (got_q.size() !== 1 || bus.words_out !== 16'd1)
      $display("FAIL mid_count got %0d/%0d want 1/1",
               got_q.size(), bus.words_out);
    else pass++;
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    mon_en = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h90;
    bus.in_last   = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    idle();
    step();
    step();
    tot++;
    if (bus.words_out !== 16'd0)
      $display("FAIL wrap_65536 got %0d want 0",
               bus.words_out);
    else pass++;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h90;
    bus.in_last  = 1'b1;
    step();
    idle();
    step();
    step();
    tot++;
    if (bus.words_out !== 16'd1)
      $display("FAIL wrap_65537 got %0d want 1",
               bus.words_out);
    else pass++;
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_relu();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
